// File: rtl/pointconv_accum.sv
// Pointwise-conv accumulator: sums LANES-wide partial products over input maps per position, then drains the tile.
// Optional POINTCONV_ACCUM_RELU_EN clamps negative drained lanes to zero (buffer contents unaffected).
module pointconv_accum #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [LANES*DW-1:0] indata,
  input  logic [31:0]         inposition,
  input  logic [4:0]          inmap_in,
  input  logic [5:0]          num_inmaps,
  input  logic [AW:0]         num_positions,
  input  logic                layer_done_in,
  output logic                rdy,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [AW-1:0]       wr_addr,
  output logic [LANES*DW-1:0] wr_data,
  output logic                tile_done,
  output logic                layer_done_out,
  output logic                pos_err
);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_e;

  state_e state_q, state_d;

  logic [LANES*DW-1:0] mem_q [DEPTH];
  logic [LANES*DW-1:0] sum_vec;
  logic [LANES*DW-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d, nxt_addr;
  logic                wr_valid_q, wr_valid_d;
  logic                tile_done_q, tile_done_d;
  logic                pos_err_q, pos_err_d;
  logic                pend_q, pend_d;

  logic [AW-1:0] idx;
  logic [31:0]   npos32;
  logic [5:0]    eff_inmaps;
  logic          accept, in_range, last_beat, drain_last, drain_fire;

  function automatic logic [LANES*DW-1:0] drain_fmt(input logic [LANES*DW-1:0] v);
    logic [LANES*DW-1:0] r;
    r = v;
`ifdef POINTCONV_ACCUM_RELU_EN
    for (int unsigned i = 0; i < LANES; i++) begin
      if (v[i*DW + DW - 1]) r[i*DW +: DW] = '0;
    end
`endif
    return r;
  endfunction

  assign idx        = inposition[AW-1:0];
  assign npos32     = {{(32-AW-1){1'b0}}, num_positions};
  assign eff_inmaps = (num_inmaps == '0) ? 6'd1 : num_inmaps;
  assign accept     = (state_q == ACCUM) && valid_in;
  assign in_range   = inposition < npos32;
  assign last_beat  = in_range && ({1'b0, inmap_in} == eff_inmaps - 6'd1)
                      && (inposition == npos32 - 32'd1);
  assign drain_last = ({1'b0, wr_addr_q} == num_positions - 1'b1);
  assign drain_fire = wr_valid_q && wr_ready;
  assign nxt_addr   = wr_addr_q + 1'b1;

  // Read side is the registered array itself, so a beat to the same idx next cycle sees this cycle's write.
  always_comb begin
    sum_vec = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_vec[i*DW +: DW] = mem_q[idx][i*DW +: DW] + indata[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      mem_q[idx] <= (inmap_in == '0) ? indata : sum_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: begin
        if (accept && last_beat)           state_d = DRAIN;
        else if (layer_done_in && !accept) state_d = DONE;
      end
      DRAIN: begin
        if (drain_fire && drain_last) state_d = (pend_q || layer_done_in) ? DONE : ACCUM;
      end
      DONE:    state_d = DONE;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    rdy            = (state_q == ACCUM);
    layer_done_out = (state_q == DONE);
  end

  // First DRAIN cycle always has wr_valid_q low, which is used to load entry 0.
  always_comb begin
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    tile_done_d = 1'b0;
    pos_err_d   = pos_err_q;
    pend_d      = pend_q;
    if (accept && !in_range) pos_err_d = 1'b1;
    if (accept && last_beat && layer_done_in) pend_d = 1'b1;
    if (state_q == DRAIN) begin
      if (layer_done_in) pend_d = 1'b1;
      if (!wr_valid_q) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = '0;
        wr_data_d  = drain_fmt(mem_q[0]);
      end else if (wr_ready) begin
        if (drain_last) begin
          wr_valid_d  = 1'b0;
          tile_done_d = 1'b1;
          pend_d      = 1'b0;
        end else begin
          wr_addr_d = nxt_addr;
          wr_data_d = drain_fmt(mem_q[nxt_addr]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tile_done_q <= 1'b0;
      pos_err_q   <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tile_done_q <= tile_done_d;
      pos_err_q   <= pos_err_d;
      pend_q      <= pend_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign tile_done = tile_done_q;
  assign pos_err   = pos_err_q;

endmodule

// File: tb/tb_pointconv_accum.sv
// Directed bench for pointconv_accum: array model of the accumulation buffer plus a per-cycle drain checker.
module tb_pointconv_accum;
  localparam int unsigned LANES = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned W     = LANES * DW;

  logic          clk = 1'b0;
  logic          reset, valid_in, layer_done_in, wr_ready;
  logic [W-1:0]  indata;
  logic [31:0]   inposition;
  logic [4:0]    inmap_in;
  logic [5:0]    num_inmaps;
  logic [AW:0]   num_positions;
  logic          rdy, wr_valid, tile_done, layer_done_out, pos_err;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pointconv_accum #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .indata(indata),
    .inposition(inposition), .inmap_in(inmap_in), .num_inmaps(num_inmaps),
    .num_positions(num_positions), .layer_done_in(layer_done_in), .rdy(rdy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .tile_done(tile_done), .layer_done_out(layer_done_out), .pos_err(pos_err)
  );

  logic [DW-1:0] mbuf [DEPTH][LANES];
  logic [AW-1:0] exp_addr_q [$];
  logic [W-1:0]  exp_data_q [$];
  logic [W-1:0]  got [DEPTH];
  int            tiles_seen = 0;
  int            beats_seen = 0;
  bit            stall_mode = 1'b0;
  int            cyc = 0;
  logic [3:0]    pat = 4'b1001;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] splat(input logic [DW-1:0] v);
    logic [W-1:0] r;
    for (int unsigned i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] out_fmt(input logic [DW-1:0] v);
`ifdef POINTCONV_ACCUM_RELU_EN
    if ($signed(v) < 0) return '0;
`endif
    return v;
  endfunction

  task automatic send(input int pos, input int map, input logic [W-1:0] v);
    int eff;
    int np;
    logic [W-1:0] e;
    eff = (num_inmaps == 0) ? 1 : int'(num_inmaps);
    np  = int'(num_positions);
    valid_in = 1'b1; indata = v; inposition = 32'(pos); inmap_in = 5'(map);
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (pos < np) begin
      for (int unsigned i = 0; i < LANES; i++)
        mbuf[pos][i] = (map == 0) ? v[i*DW +: DW] : mbuf[pos][i] + v[i*DW +: DW];
      if (map == eff - 1 && pos == np - 1) begin
        for (int p = 0; p < np; p++) begin
          for (int unsigned i = 0; i < LANES; i++) e[i*DW +: DW] = out_fmt(mbuf[p][i]);
          exp_addr_q.push_back(AW'(p));
          exp_data_q.push_back(e);
        end
      end
    end
  endtask

  task automatic tile_uniform(input int nmaps, input int npos);
    num_inmaps = 6'(nmaps); num_positions = 7'(npos);
    for (int m = 0; m < ((nmaps == 0) ? 1 : nmaps); m++)
      for (int p = 0; p < npos; p++) send(p, m, splat(DW'(m + 1)));
  endtask

  task automatic wait_drain(input string name);
    int t0;
    int n;
    t0 = tiles_seen;
    n = 0;
    while (tiles_seen == t0 && n < 300) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_tile_done_once"}, W'(tiles_seen - t0), W'(1));
    chk({name, "_all_drained"}, W'(exp_addr_q.size()), W'(0));
  endtask

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      wr_ready = stall_mode ? pat[cyc % 4] : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wr_valid) begin
          chk("beat_expected", W'(exp_addr_q.size() != 0), W'(1));
          if (exp_addr_q.size() != 0) begin
            chk("wr_addr", W'(wr_addr), W'(exp_addr_q[0]));
            chk("wr_data", wr_data, exp_data_q[0]);
            if (wr_ready) begin
              got[wr_addr] = wr_data;
              void'(exp_addr_q.pop_front());
              void'(exp_data_q.pop_front());
              beats_seen++;
            end
          end
        end
        if (tile_done) begin
          tiles_seen++;
          chk("tile_done_after_last", W'(exp_addr_q.size()), W'(0));
        end
      end
    end
  end

  initial begin
    int b0;
    reset = 1'b1; valid_in = 1'b0; indata = '0; inposition = '0; inmap_in = '0;
    num_inmaps = 6'd3; num_positions = 7'd4; layer_done_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", W'(rdy), W'(1));
    chk("rst_wr_valid", W'(wr_valid), W'(0));
    chk("rst_wr_addr", W'(wr_addr), W'(0));
    chk("rst_wr_data", wr_data, W'(0));
    chk("rst_tile_done", W'(tile_done), W'(0));
    chk("rst_layer_done", W'(layer_done_out), W'(0));
    chk("rst_pos_err", W'(pos_err), W'(0));
    reset = 1'b0;

    // Tile A: 3 maps x 4 positions, lanes = map+1, so every sum is 6.
    tile_uniform(3, 4);
    chk("lat_c1_wr_valid", W'(wr_valid), W'(0));
    chk("lat_c1_rdy", W'(rdy), W'(0));
    @(posedge clk); #1;
    chk("lat_c2_wr_valid", W'(wr_valid), W'(1));
    chk("lat_c2_wr_addr", W'(wr_addr), W'(0));
    wait_drain("tileA");
    chk("tileA_pos0_lane0", W'(got[0][31:0]), W'(6));
    chk("tileA_pos3_lane7", W'(got[3][255:224]), W'(6));
    chk("tileA_rdy_back", W'(rdy), W'(1));

    // Tile B: same tile under wr_ready stalls.
    b0 = beats_seen;
    stall_mode = 1'b1;
    tile_uniform(3, 4);
    wait_drain("tileB");
    stall_mode = 1'b0;
    chk("tileB_beats", W'(beats_seen - b0), W'(4));

    // Tile C: single map of ones must overwrite stale sums.
    tile_uniform(1, 4);
    wait_drain("tileC");
    chk("tileC_pos2_lane0", W'(got[2][31:0]), W'(1));

    // Tile D: num_inmaps=0 acts as 1; one out-of-range beat dropped.
    chk("tileD_pos_err_pre", W'(pos_err), W'(0));
    num_inmaps = 6'd0; num_positions = 7'd4;
    send(0, 0, splat(32'd9));
    send(1, 0, splat(32'd9));
    send(2, 0, splat(32'd9));
    send(5, 0, splat(32'd77));
    chk("tileD_pos_err", W'(pos_err), W'(1));
    send(3, 0, splat(32'd9));
    wait_drain("tileD");
    chk("tileD_pos1_lane0", W'(got[1][31:0]), W'(9));
    chk("tileD_pos_err_sticky", W'(pos_err), W'(1));

    // Tile E: wraparound and negative sums.
    num_inmaps = 6'd2; num_positions = 7'd2;
    send(0, 0, splat(32'hFFFF_FFFF));
    send(1, 0, splat(32'hFFFF_FFFF));
    send(0, 1, splat(32'd2));
    send(1, 1, splat(32'hFFFF_FFFE));
    wait_drain("tileE");
    chk("tileE_wrap", W'(got[0][31:0]), W'(32'h0000_0001));
`ifdef POINTCONV_ACCUM_RELU_EN
    chk("tileE_neg", W'(got[1][63:32]), W'(32'h0000_0000));
`else
    chk("tileE_neg", W'(got[1][63:32]), W'(32'hFFFF_FFFD));
`endif

    // Tile F: layer_done during a stalled drain.
    stall_mode = 1'b1;
    tile_uniform(1, 4);
    repeat (3) @(posedge clk);
    #1;
    layer_done_in = 1'b1;
    @(posedge clk); #1;
    layer_done_in = 1'b0;
    wait_drain("tileF");
    stall_mode = 1'b0;
    chk("tileF_layer_done", W'(layer_done_out), W'(1));
    chk("tileF_rdy", W'(rdy), W'(0));
    chk("tileF_wr_valid", W'(wr_valid), W'(0));
    valid_in = 1'b1; indata = splat(32'd5); inposition = 32'd3; inmap_in = 5'd0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold_layer", W'(layer_done_out), W'(1));
    chk("done_hold_rdy", W'(rdy), W'(0));

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_layer_done", W'(layer_done_out), W'(0));
    chk("rst2_rdy", W'(rdy), W'(1));
    chk("rst2_pos_err", W'(pos_err), W'(0));
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
